mem_copy_dma: RTL

- Initiator-side engine for the single-port 256x8 data memory: copies a block of bytes from a source address to a destination address.
- Drives the memory's address, write-enable and write-data inputs, and reads the memory's data output.
- Sits beside the core. It requests the memory port through a request/grant pair so the core's own loads and stores keep priority.
- Started by a one-cycle pulse. Reports completion with a one-cycle Done pulse.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/dma_addr_ctr.sv | 47 ++++
 rtl/mem_copy_dma.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg : shared types for the 256x8 data-memory initiators
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } dma_state_t;

  // One memory-port request as seen by the core-side arbiter.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic                  we;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic is_active(input dma_state_t s);
    return (s == RD) || (s == WAIT) || (s == WR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dma_addr_ctr.sv
// ---------------------------------------------------------------------------
// dma_addr_ctr : source/destination pointers and remaining-byte counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dma_addr_ctr
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] src_in,
  input  logic [ADDR_W-1:0] dst_in,
  input  logic [ADDR_W-1:0] len_in,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic              last
);

  logic [ADDR_W-1:0] remaining;

  // Pointers wrap naturally at 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
    end else if (load) begin
      src_ptr   <= src_in;
      dst_ptr   <= dst_in;
      remaining <= len_in;
    end else if (advance) begin
      src_ptr   <= src_ptr + 1'b1;
      dst_ptr   <= dst_ptr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  assign last = (remaining == ADDR_W'(1));

endmodule

`default_nettype wire

// File: rtl/mem_copy_dma.sv
// ---------------------------------------------------------------------------
// mem_copy_dma : byte-wise forward block copy over a granted memory port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_copy_dma
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W-1:0] Len,
  input  logic              Abort,
  output logic              Busy,
  output logic              Done,
  output logic              MemReq,
  input  logic              MemGnt,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWriteEn,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData
);

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT);

  dma_state_t        state;
  dma_state_t        state_nx;
  logic              load;
  logic              advance;
  logic              capture;
  logic              last;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [DATA_W-1:0] data_reg;
  logic [1:0]        lat_cnt;

  dma_addr_ctr #(
    .ADDR_W (ADDR_W)
  ) u_addr_ctr (
    .clk     (Clk),
    .rst_n   (Reset),
    .load    (load),
    .advance (advance),
    .src_in  (SrcAddr),
    .dst_in  (DstAddr),
    .len_in  (Len),
    .src_ptr (src_ptr),
    .dst_ptr (dst_ptr),
    .last    (last)
  );

  // Abort beats grant everywhere, so a cancelled cycle neither reads nor writes.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    advance  = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          if (Len != '0) begin
            load     = 1'b1;
            state_nx = RD;
          end else begin
            state_nx = DONE;
          end
        end
      end
      RD: begin
        if (Abort) begin
          state_nx = IDLE;
        end else if (MemGnt) begin
          if (RD_LAT == 0) begin
            capture  = 1'b1;
            state_nx = WR;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (Abort) begin
          state_nx = IDLE;
        end else if (lat_cnt == 2'd1) begin
          capture  = 1'b1;
          state_nx = WR;
        end
      end
      WR: begin
        if (Abort) begin
          state_nx = IDLE;
        end else if (MemGnt) begin
          advance  = 1'b1;
          state_nx = last ? DONE : RD;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      MemReq   <= 1'b0;
      data_reg <= '0;
      lat_cnt  <= '0;
    end else begin
      state  <= state_nx;
      Busy   <= is_active(state_nx);
      MemReq <= is_active(state_nx);
      Done   <= (state_nx == DONE);
      if (capture) begin
        data_reg <= MemRData;
      end
      if (state == RD && MemGnt && !Abort) begin
        lat_cnt <= LAT_LOAD;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
    end
  end

  // Port drive decodes only registered state, plus the grant/abort write gate.
  always_comb begin
    MemAddr    = '0;
    MemWData   = '0;
    MemWriteEn = 1'b0;
    case (state)
      RD, WAIT: MemAddr = src_ptr;
      WR: begin
        MemAddr    = dst_ptr;
        MemWData   = data_reg;
        MemWriteEn = MemGnt && !Abort;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
